draw_sequencer: RTL and testbench

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

---
 rtl/draw_sequencer.sv | 143 ++++++++++++++
 tb/tb_draw_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// draw_sequencer: frame-paced arbiter that grants car slots one at a time
// and routes only the granted slot's pixel writes onto the VGA port.
module draw_sequencer #(
    parameter int NUM_CARS     = 4,
    parameter int FRAME_CYCLES = 833334,
    parameter int SLOT_TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    run,
    input  logic [NUM_CARS-1:0]     car_active,
    input  logic [NUM_CARS-1:0]     car_we,
    input  logic [15*NUM_CARS-1:0]  car_coords,
    input  logic [9*NUM_CARS-1:0]   car_colour,
    input  logic [NUM_CARS-1:0]     car_done,
    output logic [NUM_CARS-1:0]     enable_draw,
    output logic                    vga_WriteEn,
    output logic [14:0]             vga_coords,
    output logic [8:0]              vga_colour,
    output logic                    frame_tick,
    output logic                    busy,
    output logic                    overrun
);

    localparam int FC_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int IDX_W = $clog2(NUM_CARS + 1);
    localparam int TO_W  = (SLOT_TIMEOUT > 1) ? $clog2(SLOT_TIMEOUT) : 1;

    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FRAME_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(SLOT_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_CARS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        SELECT,
        GRANT,
        WAIT_DONE
    } state_t;

    state_t              state;
    logic [FC_W-1:0]     frame_cnt;
    logic [IDX_W-1:0]    idx;
    logic [TO_W-1:0]     slot_timer;

    logic [NUM_CARS-1:0] idx_onehot;
    logic                sel_active;
    logic                sel_done;
    logic                sel_we;
    logic [14:0]         sel_coords;
    logic [8:0]          sel_colour;

    // Slot mux; an index of NUM_CARS selects nothing.
    always_comb begin
        idx_onehot = '0;
        sel_active = 1'b0;
        sel_done   = 1'b0;
        sel_we     = 1'b0;
        sel_coords = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (idx == IDX_W'(i)) begin
                idx_onehot[i] = 1'b1;
                sel_active    = car_active[i];
                sel_done      = car_done[i];
                sel_we        = car_we[i];
                sel_coords    = car_coords[15*i +: 15];
                sel_colour    = car_colour[9*i +: 9];
            end
        end
    end

    assign frame_tick  = (frame_cnt == FC_LAST);
    assign busy        = (state == GRANT) || (state == WAIT_DONE);
    assign enable_draw = (state == GRANT) ? idx_onehot : '0;
    assign vga_WriteEn = busy ? sel_we : 1'b0;
    assign vga_coords  = busy ? sel_coords : '0;
    assign vga_colour  = busy ? sel_colour : '0;

    always_ff @(posedge clk) begin
        if (resetn) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state      <= IDLE;
            idx        <= '0;
            slot_timer <= '0;
            overrun    <= 1'b0;
        end else begin
            // A boundary mid-sequence is only flagged; the frame runs on.
            if (frame_tick && state != IDLE && state != WAIT_FRAME) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (frame_tick) begin
                        state <= SELECT;
                        idx   <= '0;
                    end
                end
                SELECT: begin
                    if (idx == IDX_END) begin
                        state <= run ? WAIT_FRAME : IDLE;
                    end else if (!sel_active) begin
                        idx <= idx + IDX_W'(1);
                    end else begin
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    slot_timer <= '0;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (sel_done || slot_timer == TO_LAST) begin
                        idx   <= idx + IDX_W'(1);
                        state <= SELECT;
                    end else begin
                        slot_timer <= slot_timer + TO_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: scoreboard of expected grants (slot, spacing, busy
// window) plus directed reset, timeout, run-drop and overrun scenarios.
`timescale 1ns/1ps
module tb_draw_sequencer;

    localparam int NC = 4;
    localparam int FC = 100;
    localparam int TO = 16;

    typedef struct {
        int slot;
        int gap;
        int hold;
        bit first;
    } grant_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic            run;
    logic [NC-1:0]   car_active;
    logic [NC-1:0]   car_we;
    logic [15*NC-1:0] car_coords;
    logic [9*NC-1:0] car_colour;
    logic [NC-1:0]   car_done;

    logic [NC-1:0]   enable_draw;
    logic            vga_WriteEn;
    logic [14:0]     vga_coords;
    logic [8:0]      vga_colour;
    logic            frame_tick;
    logic            busy;
    logic            overrun;

    logic [NC-1:0]   ovr_enable_draw;
    logic            ovr_WriteEn;
    logic [14:0]     ovr_coords;
    logic [8:0]      ovr_colour;
    logic            ovr_frame_tick;
    logic            ovr_busy;
    logic            ovr_overrun;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    grant_t sb[$];
    int     done_dly[NC];
    bit     no_done[NC];
    bit     noise = 0;
    bit     watch_ovr = 0;
    bit     mon_en = 1;

    always #5 clk = ~clk;

    draw_sequencer #(
        .NUM_CARS(NC), .FRAME_CYCLES(FC), .SLOT_TIMEOUT(TO)
    ) u_dut (
        .clk(clk), .resetn(resetn), .run(run),
        .car_active(car_active), .car_we(car_we),
        .car_coords(car_coords), .car_colour(car_colour),
        .car_done(car_done), .enable_draw(enable_draw),
        .vga_WriteEn(vga_WriteEn), .vga_coords(vga_coords),
        .vga_colour(vga_colour), .frame_tick(frame_tick),
        .busy(busy), .overrun(overrun)
    );

    draw_sequencer #(
        .NUM_CARS(NC), .FRAME_CYCLES(FC), .SLOT_TIMEOUT(4096)
    ) u_ovr (
        .clk(clk), .resetn(resetn), .run(run),
        .car_active(car_active), .car_we(car_we),
        .car_coords(car_coords), .car_colour(car_colour),
        .car_done(car_done), .enable_draw(ovr_enable_draw),
        .vga_WriteEn(ovr_WriteEn), .vga_coords(ovr_coords),
        .vga_colour(ovr_colour), .frame_tick(ovr_frame_tick),
        .busy(ovr_busy), .overrun(ovr_overrun)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [NC-1:0] act);
        grant_t e;
        int k = 0;
        int ph = -1;
        for (int i = 0; i < NC; i++) begin
            if (!act[i]) begin
                k++;
            end else begin
                e.slot  = i;
                e.first = (ph < 0);
                e.gap   = (ph < 0) ? 2 + k : ph + 2 + k;
                e.hold  = (no_done[i] || done_dly[i] > TO) ? TO : done_dly[i];
                sb.push_back(e);
                ph = e.hold;
                k  = 0;
            end
        end
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            step(1);
            n++;
        end
        if (sb.size() != 0) begin
            chk({tag, "_timeout"}, 64'(sb.size()), 0);
            sb.delete();
        end
    endtask

    // Car model: pulses car_done done_dly cycles after its grant.
    initial begin : responder
        int cnt[NC];
        int cur;
        logic [NC-1:0] g;
        cur = -1;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        car_done = '0;
        forever begin
            @(posedge clk);
            #1;
            car_done = '0;
            g = watch_ovr ? ovr_enable_draw : enable_draw;
            for (int i = 0; i < NC; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) car_done[i] = 1'b1;
                end
                if (noise && i != cur && $urandom_range(0, 3) == 0)
                    car_done[i] = 1'b1;
            end
            for (int i = 0; i < NC; i++) begin
                if (g[i]) begin
                    cur = i;
                    if (!no_done[i]) cnt[i] = done_dly[i];
                end
            end
        end
    end

    initial begin : monitor
        int last_tick, last_grant, busy_until, rst_cyc, cur;
        bit rs;
        grant_t e;
        logic [24:0] vexp;
        last_tick  = -1;
        last_grant = -1;
        busy_until = -1;
        rst_cyc    = -1;
        cur        = 0;
        forever begin
            @(posedge clk);
            rs = resetn;
            cyc++;
            @(negedge clk);
            if (rs) begin
                last_tick  = -1;
                last_grant = -1;
                busy_until = -1;
                rst_cyc    = cyc;
            end
            if (frame_tick) begin
                if (last_tick >= 0)
                    chk("tick_period", 64'(cyc - last_tick), FC);
                else if (rst_cyc >= 0)
                    chk("tick_first", 64'(cyc - rst_cyc), FC - 1);
                last_tick = cyc;
                rst_cyc   = -1;
            end
            if (mon_en) begin
                if (enable_draw != '0) begin
                    if (sb.size() == 0) begin
                        chk("grant_unexp", 64'(enable_draw), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("grant_slot", 64'(enable_draw), 64'(1) << e.slot);
                        chk("grant_gap",
                            64'(cyc - (e.first ? last_tick : last_grant)),
                            64'(e.gap));
                        cur        = e.slot;
                        busy_until = cyc + e.hold;
                    end
                    last_grant = cyc;
                end
                chk("busy", 64'(busy), 64'(busy_until >= cyc));
                vexp = '0;
                if (busy)
                    vexp = {car_we[cur], car_coords[15*cur +: 15],
                            car_colour[9*cur +: 9]};
                chk("vga", {vga_WriteEn, vga_coords, vga_colour}, 64'(vexp));
            end
        end
    end

    initial begin : main
        int n;
        int g0;
        resetn     = 1'b1;
        run        = 1'b0;
        car_active = '1;
        car_we     = 4'b0101;
        car_coords = {15'h4321, 15'h2A5C, 15'h1234, 15'h0F0F};
        car_colour = {9'h1C3, 9'h0AA, 9'h155, 9'h03C};
        done_dly   = '{5, 5, 5, 5};
        no_done    = '{0, 0, 0, 0};
        step(3);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_enable", 64'(enable_draw), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_tick", 64'(frame_tick), 0);
        chk("rst_vga", {vga_WriteEn, vga_coords, vga_colour}, 0);

        // All slots active, fixed 5-cycle draws, three frames.
        step(0);
        run = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(4'b1111);
        drain("all_active", 600);
        run = 1'b0;
        step(FC + 20);
        chk("all_busy_end", 64'(busy), 0);
        chk("all_overrun", 64'(overrun), 0);

        // Only slots 1 and 3 active; inactive slots write constantly.
        car_active = 4'b1010;
        car_we     = 4'b1111;
        run = 1'b1;
        for (int f = 0; f < 2; f++) push_frame(car_active);
        drain("sparse", 400);
        run = 1'b0;
        step(FC + 20);

        // Slot 2 silent (timeout), slot 1 done coincides with timeout.
        car_active = 4'b1111;
        car_we     = 4'b1010;
        done_dly   = '{5, 16, 5, 5};
        no_done    = '{0, 0, 1, 0};
        noise      = 1'b1;
        run = 1'b1;
        for (int f = 0; f < 2; f++) push_frame(4'b1111);
        drain("timeout", 400);
        run = 1'b0;
        step(FC + 20);
        noise   = 1'b0;
        no_done = '{0, 0, 0, 0};
        chk("timeout_overrun", 64'(overrun), 0);

        // run dropped while slot 1 is granted.
        done_dly = '{5, 5, 5, 5};
        run = 1'b1;
        push_frame(4'b1111);
        n = 0;
        while (sb.size() > 2 && n < 300) begin
            step(1);
            n++;
        end
        chk("rundrop_reach", 64'(sb.size()), 2);
        run = 1'b0;
        drain("rundrop", 100);
        step(FC + 20);
        chk("rundrop_busy", 64'(busy), 0);

        // Reset while slot 1 is granted and writing 0x1234.
        car_we   = 4'b1111;
        done_dly = '{5, 10, 5, 5};
        run = 1'b1;
        push_frame(4'b0011);
        drain("midrst_pre", 300);
        step(1);
        @(negedge clk);
        chk("midrst_we_on", 64'(vga_WriteEn), 1);
        chk("midrst_coords_on", 64'(vga_coords), 64'h1234);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step(1);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_we", 64'(vga_WriteEn), 0);
        chk("midrst_coords", 64'(vga_coords), 0);
        chk("midrst_enable", 64'(enable_draw), 0);
        push_frame(4'b1111);
        step(0);
        drain("midrst_post", 300);
        run = 1'b0;
        step(FC + 20);
        chk("midrst_overrun", 64'(overrun), 0);

        // Overrun: slot 0 draws for 150 cycles on the long-timeout instance.
        mon_en    = 1'b0;
        watch_ovr = 1'b1;
        done_dly  = '{150, 5, 5, 5};
        car_we    = 4'b0001;
        resetn = 1'b1;
        step(2);
        resetn = 1'b0;
        run    = 1'b1;
        n = 0;
        while (ovr_enable_draw != 4'b0001 && n < 300) begin
            step(1);
            n++;
        end
        chk("ovr_first_grant", 64'(ovr_enable_draw), 4'b0001);
        g0 = cyc;
        n = 0;
        while (!ovr_frame_tick && n < 200) begin
            step(1);
            n++;
        end
        chk("ovr_tick_seen", 64'(ovr_frame_tick), 1);
        chk("ovr_pre", 64'(ovr_overrun), 0);
        chk("ovr_busy_at_tick", 64'(ovr_busy), 1);
        step(1);
        chk("ovr_set", 64'(ovr_overrun), 1);
        chk("ovr_no_restart", 64'(ovr_enable_draw), 0);
        chk("ovr_vga", {ovr_WriteEn, ovr_coords, ovr_colour},
            {1'b1, 15'h0F0F, 9'h03C});
        n = 0;
        while (ovr_enable_draw == '0 && n < 200) begin
            step(1);
            n++;
        end
        chk("ovr_next_slot", 64'(ovr_enable_draw), 4'b0010);
        chk("ovr_next_gap", 64'(cyc - g0), 152);
        n = 0;
        while (!ovr_frame_tick && n < 200) begin
            step(1);
            n++;
        end
        chk("ovr_tick2_seen", 64'(ovr_frame_tick), 1);
        step(2);
        chk("ovr_new_frame", 64'(ovr_enable_draw), 4'b0001);
        run = 1'b0;
        step(3 * FC);
        chk("ovr_sticky", 64'(ovr_overrun), 1);
        chk("ovr_idle", 64'(ovr_busy), 0);
        resetn = 1'b1;
        step(1);
        resetn = 1'b0;
        chk("ovr_clear", 64'(ovr_overrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
